// File: rtl/mod_add_stream.sv
// Streaming two-stage modular adder, out = (a + b) mod q, over a burst of N pairs under start/done.
// Optional sticky operand range flag when MOD_ADD_RANGE_CHECK_EN is defined.
`ifndef BIT_WIDTH
`define BIT_WIDTH 64
`endif

module mod_add_stream #(
  parameter int BIT_WIDTH = `BIT_WIDTH,
  parameter int LEN_W     = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [BIT_WIDTH-1:0] cfg_q,
  input  logic [LEN_W-1:0]     cfg_len,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_a,
  input  logic [BIT_WIDTH-1:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_data,
`ifdef MOD_ADD_RANGE_CHECK_EN
  output logic                 range_err,
`endif
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t               state;
  logic [BIT_WIDTH-1:0] q_r;
  logic [LEN_W-1:0]     len_r;
  logic [LEN_W-1:0]     acc_cnt;
  logic [LEN_W-1:0]     out_cnt;

  logic                 s1_valid;
  logic [BIT_WIDTH-1:0] s1_s;
  logic [BIT_WIDTH-1:0] s1_d;
  logic                 s1_neg;

  logic                 s1_adv;
  logic                 s2_adv;
  logic                 in_fire;
  logic                 out_fire;
  logic [BIT_WIDTH:0]   sum;
  logic [BIT_WIDTH+1:0] diff;
  logic                 unused_diff_bit;

  // Valid/ready: a beat transfers on any cycle where valid && ready are both high;
  // a producer holding valid keeps its data stable until the transfer happens.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = (state == S_RUN) && (acc_cnt < len_r) && s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign busy     = (state != S_IDLE);
  assign dbg_state = state;

  // s needs one carry bit, d one more for the sign; bit BIT_WIDTH of d is never
  // needed because a non-negative d is below q for in-range operands.
  assign sum  = {1'b0, in_a} + {1'b0, in_b};
  assign diff = {1'b0, sum} - {2'b00, q_r};
  assign unused_diff_bit = diff[BIT_WIDTH];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= S_IDLE;
      q_r     <= '0;
      len_r   <= '0;
      acc_cnt <= '0;
      out_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (in_fire)  acc_cnt <= acc_cnt + ONE;
      if (out_fire) out_cnt <= out_cnt + ONE;
      case (state)
        S_IDLE: begin
          if (start) begin
            q_r     <= cfg_q;
            len_r   <= cfg_len;
            acc_cnt <= '0;
            out_cnt <= '0;
            state   <= (cfg_len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (in_fire && (acc_cnt == len_r - ONE)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (out_fire && (out_cnt == len_r - ONE)) state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      s1_s      <= '0;
      s1_d      <= '0;
      s1_neg    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_fire;
        if (in_fire) begin
          s1_s   <= sum[BIT_WIDTH-1:0];
          s1_d   <= diff[BIT_WIDTH-1:0];
          s1_neg <= diff[BIT_WIDTH+1];
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) out_data <= s1_neg ? s1_s : s1_d;
      end
    end
  end

`ifdef MOD_ADD_RANGE_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      range_err <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      range_err <= 1'b0;
    end else if (in_fire && ((in_a >= q_r) || (in_b >= q_r))) begin
      range_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mod_add_stream.sv
// Bench for mod_add_stream: vector table, hand-written corner sequences and
// randomized bursts checked against an arithmetic (a + b) % q model.
module tb_mod_add_stream;

  localparam int W  = 64;
  localparam int LW = 8;
  localparam logic [W-1:0] QM = '1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [W-1:0]  cfg_q;
  logic [LW-1:0] cfg_len;
  logic          busy;
  logic          done;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    dbg_state;
`ifdef MOD_ADD_RANGE_CHECK_EN
  logic          range_err;
`endif

  mod_add_stream #(.BIT_WIDTH(W), .LEN_W(LW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_q(cfg_q), .cfg_len(cfg_len),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data),
`ifdef MOD_ADD_RANGE_CHECK_EN
    .range_err(range_err),
`endif
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  logic [W-1:0] va[$];
  logic [W-1:0] vb[$];
  logic [W-1:0] vexp[$];

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;
  localparam int NT = 12;
  vec_t tbl[NT];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_add(input logic [W-1:0] q, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [W:0] s;
    logic [W:0] r;
    s = {1'b0, a} + {1'b0, b};
    r = s % {1'b0, q};
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic clear_vec();
    va.delete(); vb.delete(); vexp.delete();
  endtask

  task automatic add_rand(input logic [W-1:0] q);
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = rand64() % q;
    b = rand64() % q;
    va.push_back(a); vb.push_back(b); vexp.push_back(ref_add(q, a, b));
  endtask

  // driver + monitor for one burst; mode 0: out_ready high, 1: toggling, 2: random
  task automatic run_burst(input logic [W-1:0] q, input int n, input int mode, input bit poke);
    int idx, outs, dones, start_cyc, lat;
    bit stalled, extra_ready, saw_bp;
    logic [W-1:0] held;
    idx = 0; outs = 0; dones = 0; stalled = 0; extra_ready = 0; saw_bp = 0; held = '0;
    exp_q.delete(); cyc_q.delete();
    @(posedge clk); #1;
    start = 1'b1; cfg_q = q; cfg_len = LW'(n);
    in_valid = 1'b0; out_ready = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; cfg_q = rand64(); cfg_len = LW'($urandom);
    for (int t = 0; t < 6 * n + 50 && dones == 0; t++) begin
      in_valid = (idx < n) && ((mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_a = (idx < n) ? va[idx] : '0;
      in_b = (idx < n) ? vb[idx] : '0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (t % 2 == 0);
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
      start = poke && (n >= 3) && (t == 3);
      if (start) begin
        cfg_q = 5; cfg_len = 1;
      end
      #1;
      if (t == 0) check("busy_in_burst", busy, 1);
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, held);
      end
      if (idx >= n && in_ready) extra_ready = 1;
      if (in_valid && !in_ready && out_valid && !out_ready) saw_bp = 1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", out_data, '1 ^ out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
          lat = cyc - cyc_q.pop_front();
          if (mode == 0) check("latency", 64'(lat), 2);
        end
        outs++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(vexp[idx]);
        cyc_q.push_back(cyc);
        idx++;
      end
      stalled = out_valid && !out_ready;
      held = out_data;
      if (done) begin
        dones++;
        check("busy_low_at_done", busy, 0);
        if (n == 0) check("zero_len_done_cycle", 64'(cyc - start_cyc), 2);
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (dones == 0) $display("FAIL burst_timeout: q=%0h n=%0d no done seen", q, n);
    check("done_count", 64'(dones), 1);
    check("output_count", 64'(outs), 64'(n));
    check("queue_empty", 64'(exp_q.size()), 0);
    check("no_extra_in_ready", 64'(extra_ready), 0);
    if (mode == 1 && n >= 4) check("backpressure_seen", 64'(saw_bp), 1);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    logic [W-1:0] gq;
    int idx;
    rstn = 1'b0; start = 1'b0; cfg_q = '0; cfg_len = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;

    tbl[0]  = '{64'd17, 64'd3,  64'd5,  64'd8};
    tbl[1]  = '{64'd17, 64'd16, 64'd1,  64'd0};
    tbl[2]  = '{64'd17, 64'd16, 64'd16, 64'd15};
    tbl[3]  = '{64'd17, 64'd0,  64'd0,  64'd0};
    tbl[4]  = '{QM, QM - 1, QM - 1, QM - 2};
    tbl[5]  = '{QM, 64'd1, QM - 2, QM - 1};
    tbl[6]  = '{QM, QM - 1, 64'd1, 64'd0};
    tbl[7]  = '{64'd2, 64'd1, 64'd1, 64'd0};
    tbl[8]  = '{64'd2, 64'd0, 64'd1, 64'd1};
    tbl[9]  = '{64'd2, 64'd1, 64'd0, 64'd1};
    tbl[10] = '{64'd13, 64'd8, 64'd4, 64'd12};
    tbl[11] = '{64'd13, 64'd9, 64'd4, 64'd0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
`ifdef MOD_ADD_RANGE_CHECK_EN
    check("rst_range_err", range_err, 0);
`endif
    rstn = 1'b1;

    // vector table, consecutive rows with the same q form one burst
    clear_vec();
    gq = tbl[0].q;
    for (int i = 0; i < NT; i++) begin
      if (tbl[i].q != gq) begin
        run_burst(gq, va.size(), 0, 0);
        clear_vec();
        gq = tbl[i].q;
      end
      va.push_back(tbl[i].a); vb.push_back(tbl[i].b); vexp.push_back(tbl[i].exp);
    end
    run_burst(gq, va.size(), 0, 0);

    // toggling backpressure
    clear_vec();
    for (int i = 0; i < 8; i++) add_rand(17);
    run_burst(17, 8, 1, 0);

    // empty burst
    clear_vec();
    run_burst(17, 0, 0, 0);

    // reset after 3 of 6 accepted
    clear_vec();
    for (int i = 0; i < 6; i++) add_rand(17);
    @(posedge clk); #1;
    start = 1'b1; cfg_q = 17; cfg_len = 6;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    for (int t = 0; t < 20 && idx < 3; t++) begin
      in_valid = 1'b1; in_a = va[idx]; in_b = vb[idx]; out_ready = 1'b1;
      #1;
      if (in_ready) idx++;
      @(posedge clk); #1;
    end
    check("reset_feed_count", 64'(idx), 3);
    in_valid = 1'b0; rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #2;
      check("mid_rst_no_done", {done, out_valid}, 0);
    end
    clear_vec();
    va.push_back(12); vb.push_back(12); vexp.push_back(11);
    run_burst(13, 1, 0, 0);

    // randomized bursts with a stray start mid-burst and cfg changes after start
    for (int k = 0; k < 6; k++) begin
      logic [W-1:0] q;
      int n;
      q = (k % 2 == 0) ? rand64() : 64'($urandom_range(2, 200));
      if (q < 2) q = 2;
      n = $urandom_range(1, 20);
      clear_vec();
      for (int i = 0; i < n; i++) add_rand(q);
      run_burst(q, n, 2, 1'b1);
    end

    // maximum burst length
    gq = rand64() | 64'd2;
    clear_vec();
    for (int i = 0; i < 255; i++) add_rand(gq);
    run_burst(gq, 255, 0, 0);

    // out-of-range operand
    clear_vec();
    va.push_back(17); vb.push_back(0); vexp.push_back(0);
    run_burst(17, 1, 0, 0);
`ifdef MOD_ADD_RANGE_CHECK_EN
    check("range_err_set", range_err, 1);
    repeat (3) @(posedge clk);
    #1;
    check("range_err_sticky", range_err, 1);
    clear_vec();
    va.push_back(1); vb.push_back(2); vexp.push_back(3);
    run_burst(17, 1, 0, 0);
    check("range_err_cleared", range_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_add_stream.md
Name: mod_add_stream

Overview:
- Streaming, pipelined modular adder: out = (a + b) mod q. It is the additive counterpart of the team's combinational modular subtractor.
- Processes a burst of N operand pairs under a start/done control handshake.
- Valid/ready on both the operand and result streams, with full backpressure.
- Sits between the operand buffers and the writeback path of the polynomial-arithmetic datapath.

Parameters:
- BIT_WIDTH, default `BIT_WIDTH (from common.vh), coefficient/modulus width.
- LEN_W, default 16, width of the burst-length field.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; latches cfg_q and cfg_len; honoured only in IDLE
- cfg_q  in  BIT_WIDTH  modulus q, 2 <= q < 2^BIT_WIDTH
- cfg_len  in  LEN_W  number of pairs N in the burst
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last result is accepted downstream
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts the pair this cycle
- in_a  in  BIT_WIDTH  operand a, required < q
- in_b  in  BIT_WIDTH  operand b, required < q
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  BIT_WIDTH  (a + b) mod q

Behaviour:
- Clocking: one clock; reset is synchronous and active-low (rstn sampled on the rising edge of clk).
- Reset values: busy=0, done=0, in_ready=0, out_valid=0, out_data=0. Both pipeline valid bits and all counters clear; FSM goes to IDLE.
- Reset mid-burst drops all in-flight data and emits no done.
- Arithmetic:
  - s = a + b, computed at BIT_WIDTH+1 bits.
  - d = s - q, computed at BIT_WIDTH+2 bits.
  - Result = d if d is non-negative, else s[BIT_WIDTH-1:0].
  - Correct for a, b < q; no multi-bit reduction is performed.
- Pipeline:
  - Stage 1 registers s and d.
  - Stage 2 registers the selected result into out_data.
  - Latency: a pair accepted at cycle t appears with out_valid at cycle t+2 when out_ready is held high.
  - Throughput is one pair per cycle, with no bubbles.
- Backpressure:
  - A stage advances when its downstream slot is empty or is being consumed that cycle.
  - in_ready = (state==RUN) && (acc_cnt < N) && stage 1 can advance.
  - While out_valid=1 and out_ready=0, out_data and out_valid hold stable.
  - Transfer occurs on valid && ready in the same cycle.
- FSM:
  - IDLE: on start, latch q_r=cfg_q and len_r=cfg_len, clear acc_cnt and out_cnt. Go to DONE if cfg_len==0, else to RUN.
  - RUN: accept pairs, incrementing acc_cnt. Move to DRAIN in the cycle acc_cnt reaches N.
  - DRAIN: in_ready=0. Move to DONE in the cycle out_cnt reaches N.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Counters:
  - out_cnt counts output handshakes in both RUN and DRAIN.
  - Counters are LEN_W bits. The maximum N = 2^LEN_W - 1 completes without wrap.
- q_r is stable for the whole burst; cfg_q changes after start have no effect.
- start outside IDLE is ignored; the current burst is unaffected.
- Boundaries:
  - a+b == q yields 0.
  - a+b == q-1 yields q-1.
  - q = 2^BIT_WIDTH-1 with a=b=q-1 yields q-2; the carry into bit BIT_WIDTH is handled.

Optional Feature:
- Macro: MOD_ADD_RANGE_CHECK_EN.
- When defined, adds output port range_err (out, 1, reset 0) as a sticky flag. It sets when an accepted pair has in_a >= q_r or in_b >= q_r. It clears on the next accepted start. Datapath results are unchanged (garbage-in/garbage-out).
- When undefined, the port and comparators are absent and behaviour is otherwise identical.

Test Plan:
- q=17, N=4, pairs (3,5),(16,1),(16,16),(0,0), out_ready=1 → outputs 8,0,15,0 at cycles t+2..t+5; done pulses once after the 4th; busy falls with IDLE.
- q=17, N=8 streaming, out_ready toggling 1/0 each cycle → out_data stable while stalled, no loss or duplication, order preserved, in_ready deasserts once both stages are full.
- BIT_WIDTH=64, q=2^64-1, a=b=q-1 → out = 2^64-3; a=1, b=q-2 → out = q-1.
- cfg_len=0 start → done at start+2 cycles, in_ready never asserted, no output.
- Reset mid-burst after 3 of 6 accepted (rstn low 1 cycle) → all outputs at reset values next cycle, no done; a new start q=13, N=1, (12,12) → 11.
- With MOD_ADD_RANGE_CHECK_EN, q=17, pair (17,0) → range_err=1 and remains sticky; next start clears it. Without the macro, the same stimulus completes normally.
